ss_scan_mux: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It cycles through `N_DIGITS` digit slots and presents the current 4-bit hex nibble on `digit_data` to the hex-to-segment decoder. It drives the active-low anode enables directly, with a blanking interval at the start of each slot to suppress ghosting. The displayed value is snapshotted once per frame so a digit set never tears, and optional leading-zero blanking is provided.

---
 rtl/ss_scan_mux.sv | 109 ++++++++++
 tb/tb_ss_scan_mux.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ss_scan_mux.sv
// Scan controller for a common-anode multi-digit 7-segment display.
// Registered outputs, per-slot blanking, frame snapshot, leading-zero blanking.
module ss_scan_mux #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  input  logic                  en,
  output logic [3:0]            digit_data,
  output logic                  digit_dp,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_n;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_n;
  logic [4*N_DIGITS-1:0]   snap;
  logic [4*N_DIGITS-1:0]   snap_n;
  logic                    run;
  logic                    wrap;
  logic [N_DIGITS-1:0]     blk;
  logic                    zero_hi;
  logic [3:0]              data_x;
  logic                    dp_x;
  logic [N_DIGITS-1:0]     an_x;

  // Next scan position; the first edge out of reset only arms the scan
  // so the restart slot gets its full blank interval.
  always_comb begin
    cnt_n  = cnt;
    idx_n  = idx;
    snap_n = snap;
    wrap   = 1'b0;
    if (run && en) begin
      if (cnt == CW'(SCAN_DIV - 1)) begin
        cnt_n = '0;
        if (idx == IW'(N_DIGITS - 1)) begin
          idx_n  = '0;
          wrap   = 1'b1;
          snap_n = value;
        end else begin
          idx_n = idx + IW'(1);
        end
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
  end

  // Leading-zero mask: digit k dark when it and all higher nibbles are zero.
  always_comb begin
    blk     = '0;
    zero_hi = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_hi = zero_hi & (snap_n[4*k +: 4] == 4'h0);
      blk[k]  = blank_lz & zero_hi & (k != 0);
    end
  end

  // Decode of the next state, registered below so anodes never glitch.
  always_comb begin
    data_x = 4'h0;
    dp_x   = 1'b0;
    an_x   = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_n == IW'(k)) begin
        data_x = snap_n[4*k +: 4];
        dp_x   = dp_in[k];
        if (en && (cnt_n >= CW'(BLANK_CYC)) && !blk[k]) begin
          an_x[k] = 1'b0;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      snap       <= value;
      run        <= 1'b0;
      an_n       <= '1;
      digit_data <= 4'h0;
      digit_dp   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      snap       <= snap_n;
      run        <= 1'b1;
      an_n       <= an_x;
      digit_data <= data_x;
      digit_dp   <= dp_x;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_ss_scan_mux.sv
// Bench for ss_scan_mux: position-based model checked every cycle
// plus literal expectations at key cycles of each scenario.
module tb_ss_scan_mux;

  localparam int N = 4;
  localparam int S = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h12AB;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic        en = 1'b1;
  logic [3:0]  digit_data;
  logic        digit_dp;
  logic [3:0]  an_n;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ss_scan_mux #(.N_DIGITS(N), .SCAN_DIV(S), .BLANK_CYC(B)) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .dp_in(dp_in),
    .blank_lz(blank_lz),
    .en(en),
    .digit_data(digit_data),
    .digit_dp(digit_dp),
    .an_n(an_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  // Model: the scan is a position within the frame, 0..N*S-1.
  int          pos = 0;
  logic [15:0] m_snap = 16'h0;
  bit          live = 1'b0;
  bit          mvalid = 1'b0;
  int          d, c;
  logic        lead;
  logic [3:0]  e_an, e_dd;
  logic        e_dp, e_ft;

  always @(posedge clk) begin
    if (rst) begin
      pos    = 0;
      m_snap = value;
      live   = 1'b0;
      mvalid = 1'b1;
      e_an   = 4'hF;
      e_dd   = 4'h0;
      e_dp   = 1'b0;
      e_ft   = 1'b0;
    end else begin
      e_ft = 1'b0;
      if (!live) begin
        live = 1'b1;
      end else if (en) begin
        pos = pos + 1;
        if (pos == N * S) begin
          pos    = 0;
          m_snap = value;
          e_ft   = 1'b1;
        end
      end
      d    = pos / S;
      c    = pos % S;
      e_dd = 4'((m_snap >> (4 * d)) & 16'hF);
      e_dp = dp_in[d];
      lead = blank_lz && (d > 0) && ((m_snap >> (4 * d)) == 16'h0);
      e_an = 4'hF;
      if (en && (c >= B) && !lead) e_an[d] = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_an_n", 16'(an_n), 16'(e_an));
      chk("m_digit_data", 16'(digit_data), 16'(e_dd));
      chk("m_digit_dp", 16'(digit_dp), 16'(e_dp));
      chk("m_frame_tick", 16'(frame_tick), 16'(e_ft));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input logic [15:0] v, input logic [3:0] dp,
                          input logic lz);
    rst      = 1'b1;
    value    = v;
    dp_in    = dp;
    blank_lz = lz;
    en       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an_n", 16'(an_n), 16'hF);
    chk("rst_digit_data", 16'(digit_data), 16'h0);
    chk("rst_frame_tick", 16'(frame_tick), 16'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  initial begin
    // Reset and scan order
    do_reset(16'h12AB, 4'h0, 1'b0);
    chk("c0_data", 16'(digit_data), 16'hB);
    chk("c0_an", 16'(an_n), 16'hF);
    run_to(2);  chk("c2_an", 16'(an_n), 16'hE);
    run_to(8);  chk("c8_data", 16'(digit_data), 16'hA);
    chk("c8_an", 16'(an_n), 16'hF);
    run_to(10); chk("c10_an", 16'(an_n), 16'hD);
    run_to(18); chk("c18_an", 16'(an_n), 16'hB);
    chk("c18_data", 16'(digit_data), 16'h2);
    run_to(26); chk("c26_an", 16'(an_n), 16'h7);
    chk("c26_data", 16'(digit_data), 16'h1);
    run_to(31); chk("c31_tick", 16'(frame_tick), 16'h0);
    run_to(32); chk("c32_tick", 16'(frame_tick), 16'h1);

    // Snapshot and frame tick
    do_reset(16'h1234, 4'h0, 1'b0);
    run_to(12); value = 16'h5678;
    run_to(18); chk("snap_c18", 16'(digit_data), 16'h2);
    run_to(26); chk("snap_c26", 16'(digit_data), 16'h1);
    run_to(32); chk("snap_c32", 16'(digit_data), 16'h8);
    chk("snap_tick", 16'(frame_tick), 16'h1);
    run_to(33); chk("snap_tick_off", 16'(frame_tick), 16'h0);
    run_to(40); chk("snap_c40", 16'(digit_data), 16'h7);
    run_to(56); chk("snap_c56", 16'(digit_data), 16'h5);

    // Leading-zero blanking
    do_reset(16'h0050, 4'h0, 1'b1);
    run_to(2);  chk("lz_d0_an", 16'(an_n), 16'hE);
    chk("lz_d0_data", 16'(digit_data), 16'h0);
    run_to(10); chk("lz_d1_an", 16'(an_n), 16'hD);
    chk("lz_d1_data", 16'(digit_data), 16'h5);
    run_to(18); chk("lz_d2_an", 16'(an_n), 16'hF);
    run_to(26); chk("lz_d3_an", 16'(an_n), 16'hF);
    value = 16'h0000;
    run_to(34); chk("lz0_d0_an", 16'(an_n), 16'hE);
    run_to(42); chk("lz0_d1_an", 16'(an_n), 16'hF);
    run_to(63);

    // Enable hold
    do_reset(16'h12AB, 4'h0, 1'b0);
    run_to(10); chk("en_c10_an", 16'(an_n), 16'hD);
    en = 1'b0;
    run_to(11); chk("en_c11_an", 16'(an_n), 16'hF);
    chk("en_c11_data", 16'(digit_data), 16'hA);
    run_to(30); chk("en_c30_an", 16'(an_n), 16'hF);
    en = 1'b1;
    run_to(31); chk("en_c31_an", 16'(an_n), 16'hD);
    run_to(35); chk("en_c35_an", 16'(an_n), 16'hD);
    run_to(36); chk("en_c36_an", 16'(an_n), 16'hF);
    chk("en_c36_data", 16'(digit_data), 16'h2);
    run_to(52); chk("en_c52_tick", 16'(frame_tick), 16'h1);

    // Decimal point
    do_reset(16'h12AB, 4'b0100, 1'b0);
    run_to(15); chk("dp_c15", 16'(digit_dp), 16'h0);
    run_to(16); chk("dp_c16", 16'(digit_dp), 16'h1);
    run_to(23); chk("dp_c23", 16'(digit_dp), 16'h1);
    run_to(24); chk("dp_c24", 16'(digit_dp), 16'h0);
    run_to(48); chk("dp_c48", 16'(digit_dp), 16'h1);

    // Reset mid-frame
    do_reset(16'h12AB, 4'h0, 1'b0);
    run_to(20); rst = 1'b1;
    run_to(21); chk("mr_an", 16'(an_n), 16'hF);
    chk("mr_data", 16'(digit_data), 16'h0);
    chk("mr_tick", 16'(frame_tick), 16'h0);
    rst = 1'b0;
    run_to(22); chk("mr_c0_data", 16'(digit_data), 16'hB);
    chk("mr_c0_an", 16'(an_n), 16'hF);
    run_to(23); chk("mr_c1_an", 16'(an_n), 16'hF);
    run_to(24); chk("mr_c2_an", 16'(an_n), 16'hE);
    run_to(40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
